// File: rtl/z80_incdec_seq.sv
// z80_incdec_seq: 4-clock INC/DEC unit with its own register file and F flags.
// 8-bit ops produce full Z80 flags; register-pair ops leave F untouched.
module z80_incdec_seq #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_op,
    input  logic              i_wide,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic              i_wr_en,
    input  logic [SEL_W-1:0]  i_wr_sel,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_f_wr,
    input  logic [7:0]        i_f_data,
    input  logic [SEL_W-1:0]  i_rd_sel,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [7:0]        o_f,
    output logic              o_busy,
    output logic              o_done
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
    localparam logic [SEL_W-1:0]    LSB   = SEL_W'(1);
    localparam logic [DATA_W-1:0]   ONE_N = DATA_W'(1);
    localparam logic [2*DATA_W-1:0] ONE_W = (2*DATA_W)'(1);
    state_t              state;
    logic                op_q, wide_q;
    logic [SEL_W-1:0]    sel_q, hi_i, lo_i;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [7:0]          f, f_q, nf;
    logic [2*DATA_W-1:0] opnd, res_q, wres;
    logic [DATA_W-1:0]   nar, nres;
    logic                h, pv;

    assign o_rd_data = regs[i_rd_sel];
    assign o_f       = f;
    assign o_busy    = state != IDLE;

    // Pair indices ignore sel bit 0; the even register holds the high half.
    always_comb begin
        hi_i = sel_q & ~LSB;
        lo_i = sel_q | LSB;
        nar  = opnd[DATA_W-1:0];
        nres = op_q ? nar - ONE_N : nar + ONE_N;
        wres = op_q ? opnd - ONE_W : opnd + ONE_W;
        h    = op_q ? nar[3:0] == 4'h0 : nar[3:0] == 4'hF;
        pv   = nar == (op_q ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
        nf   = {nres[DATA_W-1], nres == '0, nres[5], h, nres[3], pv, op_q, f[0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op_q   <= 1'b0;
            wide_q <= 1'b0;
            sel_q  <= '0;
            opnd   <= '0;
            res_q  <= '0;
            f_q    <= '0;
            f      <= '0;
            o_done <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_wr_en) regs[i_wr_sel] <= i_wr_data;
                    if (i_f_wr) f <= i_f_data;
                    if (i_start) begin
                        op_q   <= i_op;
                        wide_q <= i_wide;
                        sel_q  <= i_sel;
                        state  <= READ;
                    end
                end
                READ: begin
                    opnd  <= wide_q ? {regs[hi_i], regs[lo_i]} : {{DATA_W{1'b0}}, regs[sel_q]};
                    state <= EXEC;
                end
                EXEC: begin
                    res_q <= wide_q ? wres : {{DATA_W{1'b0}}, nres};
                    f_q   <= wide_q ? f : nf;
                    state <= WRITE;
                end
                WRITE: begin
                    if (wide_q) begin
                        regs[hi_i] <= res_q[2*DATA_W-1:DATA_W];
                        regs[lo_i] <= res_q[DATA_W-1:0];
                    end else begin
                        regs[sel_q] <= res_q[DATA_W-1:0];
                    end
                    f      <= f_q;
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/z80_incdec_seq.md
Name: z80_incdec_seq

Overview:
- Parametrised sequential INC/DEC execution unit for the Z80-compatible core.
- Owns a small general-register file and the F flag register.
- Performs 8-bit INC r / DEC r with full Z80 flag generation, and 16-bit register-pair INC rr / DEC rr with flags untouched.
- Uses a fixed 4-clock FSM, matching the core's 4 T-state timing for these opcodes.

Parameters:
- DATA_W, 8: register width; must be >= 8. Flag bits X/Y/H are always taken from bits 3, 5 and 3:0.
- NUM_REGS, 8: register-file depth; must be even. Pairs are (0,1), (2,3), …; the even index is the high half.
- SEL_W, $clog2(NUM_REGS): register-select width.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  request an operation; sampled only in IDLE.
- i_op  in  1  0 = INC, 1 = DEC.
- i_wide  in  1  0 = single register; 1 = register pair, selected by i_sel with bit 0 ignored.
- i_sel  in  SEL_W  target register or pair.
- i_wr_en  in  1  direct register write (setup/load path); honoured only in IDLE.
- i_wr_sel  in  SEL_W  direct-write register index.
- i_wr_data  in  DATA_W  direct-write data.
- i_f_wr  in  1  direct write of F; honoured only in IDLE.
- i_f_data  in  8  F write data.
- i_rd_sel  in  SEL_W  combinational read select.
- o_rd_data  out  DATA_W  reg[i_rd_sel], combinational.
- o_f  out  8  F register, layout S Z Y H X P/V N C (bit 7 down to bit 0).
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse in the cycle after writeback.

Behaviour:
- Reset (async assert, sync release):
  - all registers = 0, F = 0x00.
  - state = IDLE; o_busy = 0, o_done = 0.
  - Reset mid-operation aborts the operation: no writeback, no o_done.
- FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE, one state per clock.
  - Edge 0: i_start sampled high in IDLE. Latch i_op, i_wide, i_sel; go to READ.
  - Edge 1: latch the operand (register, or {reg[2k], reg[2k+1]} for a pair); go to EXEC.
  - Edge 2: compute the result and new flags into holding registers; go to WRITE.
  - Edge 3: commit the result to the register(s) and F; go to IDLE; o_done = 1 for exactly the following cycle.
  - Latency: 4 rising edges from acceptance to commit.
- i_start in any non-IDLE state is ignored; there is no queuing.
- i_wr_en and i_f_wr in a non-IDLE state are ignored.
- Direct write and i_start in the same IDLE cycle: the write commits at edge 0. The operand is latched at edge 1, so the operation sees the new value.
- A new i_start may be sampled in the o_done cycle, because the FSM is already in IDLE.
- 8-bit arithmetic: res = op ± 1 modulo 2^DATA_W.
  - S = res[DATA_W-1]
  - Z = (res == 0)
  - Y = res[5], X = res[3]
  - H: INC -> operand[3:0] == 4'hF; DEC -> operand[3:0] == 4'h0
  - P/V: INC -> operand == {0,1…1}; DEC -> operand == {1,0…0}
  - N = i_op
  - C = preserved from F
- Wide arithmetic: 2·DATA_W-bit ± 1 with wrap-around (all-ones+1 -> 0; 0-1 -> all-ones). F is unchanged.
- Wide with odd i_sel: treated as i_sel & ~1.
- o_rd_data reflects committed register contents only; there is no bypass of in-flight results.

Test Plan:
- reg[0] = 0xFF, F = 0x00; start INC, sel 0 -> after 4 clocks reg[0] = 0x00, F = 0x50, o_done pulses once, o_busy high for exactly 3 cycles.
- reg[1] = 0x7F, F = 0x01; INC sel 1 -> reg[1] = 0x80, F = 0x95 (S, H, P/V set; C preserved).
- reg[2] = 0x80, F = 0x00; DEC sel 2 -> reg[2] = 0x7F, F = 0x3E (Y, H, X, P/V, N set).
- reg[2] = 0xFF, reg[3] = 0xFF, F = 0xA5; INC wide sel 3 -> both registers 0x00, F stays 0xA5. Then DEC wide sel 2 -> both 0xFF.
- Start while busy: a second i_start at edge 1 is ignored. A direct write issued during EXEC is dropped. Exactly one o_done pulse is produced.
- Assert reset_n low during EXEC -> all registers and F read 0 immediately; no o_done; the FSM is in IDLE after release.
